i2c_instr_sequencer: RTL and testbench

//  Writable, depth-parametrised instruction store with a fetch/issue FSM.
//  On start it walks the program from start_addr and presents each I2C READ/WRITE

---
 rtl/i2c_instr_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_i2c_instr_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_instr_sequencer.sv
// Instruction store plus fetch/issue sequencer feeding an I2C master.
// Words are {op, dev, reg, data}; READ/WRITE are handed out over a
// valid/ready handshake, NOPs are skipped, and HALT or an error ends the run.
module i2c_instr_sequencer #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_op,
  output logic [7:0]        instr_dev,
  output logic [7:0]        instr_reg,
  output logic [7:0]        instr_data,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [3:0]        error_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_ADVANCE
  } state_t;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_HALT  = 8'h03;

  localparam logic [3:0] ERR_NONE  = 4'd0;
  localparam logic [3:0] ERR_RANGE = 4'd1;
  localparam logic [3:0] ERR_OP    = 4'd2;
  localparam logic [3:0] ERR_BUSY  = 4'd3;

  // One extra bit so the range test also works for non-power-of-two DEPTH.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [31:0] mem [DEPTH];

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic              valid_n;
  logic              done_n;
  logic [3:0]        err_n;
  logic              ir_load;
  logic              mem_we;
  logic [31:0]       ir;

  logic wr_in_range;
  logic start_in_range;

  assign wr_in_range    = {1'b0, wr_addr} < DEPTH_X;
  assign start_in_range = {1'b0, start_addr} < DEPTH_X;

  // Instruction store: written only from the load port, never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // State, program counter, instruction register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      error_code  <= '0;
      ir          <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr_valid <= valid_n;
      done        <= done_n;
      error_code  <= err_n;
      if (ir_load) begin
        ir <= mem[pc];
      end
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = instr_valid;
    done_n  = 1'b0;
    err_n   = error_code;
    ir_load = 1'b0;
    mem_we  = 1'b0;

    // Start clears the sticky error first so a same-cycle bad write still
    // leaves its error visible for the new run.
    if (state == S_IDLE) begin
      if (start) begin
        err_n = ERR_NONE;
        if (start_in_range) begin
          pc_n    = start_addr;
          state_n = S_FETCH;
        end else begin
          err_n  = ERR_RANGE;
          done_n = 1'b1;
        end
      end
      if (wr_en) begin
        if (wr_in_range) begin
          mem_we = 1'b1;
        end else begin
          err_n = ERR_RANGE;
        end
      end
    end else if (wr_en) begin
      err_n = ERR_BUSY;
    end

    case (state)
      S_FETCH: begin
        ir_load = 1'b1;
        state_n = S_DECODE;
      end
      S_DECODE: begin
        case (ir[31:24])
          OP_READ, OP_WRITE: begin
            valid_n = 1'b1;
            state_n = S_ISSUE;
          end
          OP_NOP: begin
            state_n = S_ADVANCE;
          end
          OP_HALT: begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
          default: begin
            err_n   = ERR_OP;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        endcase
      end
      S_ISSUE: begin
        if (instr_ready) begin
          valid_n = 1'b0;
          state_n = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (pc == LAST) begin
          err_n   = ERR_RANGE;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          pc_n    = pc + 1'b1;
          state_n = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  // Fields are masked so the master sees zeros whenever nothing is offered.
  always_comb begin
    instr_op   = instr_valid ? ir[31:24] : '0;
    instr_dev  = instr_valid ? ir[23:16] : '0;
    instr_reg  = instr_valid ? ir[15:8]  : '0;
    instr_data = instr_valid ? ir[7:0]   : '0;
    busy       = (state != S_IDLE);
  end

endmodule

// File: tb/tb_i2c_instr_sequencer.sv
// Scoreboard bench for i2c_instr_sequencer: directed programs push expected
// issues and end-of-run records; a negedge monitor pops and compares them.
module tb_i2c_instr_sequencer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        instr_op, instr_dev, instr_reg, instr_data;
  logic [ADDR_W-1:0] pc;
  logic              busy, done;
  logic [3:0]        error_code;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] exp_issue [$];
  logic [7:0]  exp_done  [$];   // {pc, error_code}

  i2c_instr_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .start_addr(start_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_dev(instr_dev),
    .instr_reg(instr_reg), .instr_data(instr_data),
    .pc(pc), .busy(busy), .done(done), .error_code(error_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares offered instructions and end-of-run records.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (instr_valid) begin
        if (exp_issue.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_issue: got %0h expected none at %0t",
                   {instr_op, instr_dev, instr_reg, instr_data}, $time);
        end else begin
          check("issue_fields", {instr_op, instr_dev, instr_reg, instr_data}, exp_issue[0]);
          if (instr_ready) void'(exp_issue.pop_front());
        end
      end
      if (done) begin
        check("done_excl_valid", {31'd0, instr_valid}, 32'd0);
        if (exp_done.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_done: got pc %0h err %0h expected none", pc, error_code);
        end else begin
          check("done_pc_err", {24'd0, pc, error_code}, {24'd0, exp_done.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run(input logic [ADDR_W-1:0] a);
    start = 1'b1; start_addr = a;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      n++;
      if (done) break;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (instr_valid) break;
      tick();
    end
    check("valid_seen", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic load_prog3();
    load(4'd0, 32'h0100F000);
    load(4'd1, 32'h021DAB32);
    load(4'd2, 32'h03000000);
  endtask

  task automatic push_prog3(input logic [3:0] err);
    exp_issue.push_back(32'h0100F000);
    exp_issue.push_back(32'h021DAB32);
    exp_done.push_back({4'd2, err});
  endtask

  int n;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_addr = '0; instr_ready = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {instr_valid, busy, done, error_code, pc,
                          instr_op, instr_dev, instr_reg, instr_data}, 32'd0);
    reset = 1'b1;
    tick();

    // Basic READ, WRITE, HALT with ready tied high; check start latency.
    instr_ready = 1'b1;
    load_prog3();
    push_prog3(4'd0);
    run(4'd0);
    check("lat_after_N", {31'd0, instr_valid}, 32'd0);
    tick();
    check("lat_after_N1", {31'd0, instr_valid}, 32'd0);
    tick();
    check("lat_after_N2", {31'd0, instr_valid}, 32'd1);
    wait_done(40, n);
    check("t1_err", {28'd0, error_code}, 32'd0);

    // Same program with a 5-cycle ready stall on the first issue.
    instr_ready = 1'b0;
    push_prog3(4'd0);
    run(4'd0);
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid_pc", {27'd0, instr_valid, pc}, {27'd0, 1'b1, 4'd0});
    end
    instr_ready = 1'b1;
    wait_done(40, n);

    // NOP then HALT from address 4.
    load(4'd4, 32'h00000000);
    load(4'd5, 32'h03000000);
    exp_done.push_back({4'd5, 4'd0});
    run(4'd4);
    wait_done(20, n);
    check("nop_done_cycles", n, 32'd5);
    check("nop_pc", {28'd0, pc}, 32'd5);

    // Last word has no HALT: one issue then range error, pc held.
    load(4'(DEPTH - 1), 32'h01112233);
    exp_issue.push_back(32'h01112233);
    exp_done.push_back({4'(DEPTH - 1), 4'd1});
    run(4'(DEPTH - 1));
    wait_done(20, n);
    tick();
    check("end_pc_err", {24'd0, pc, error_code}, {24'd0, 4'(DEPTH - 1), 4'd1});

    // Illegal opcode.
    load(4'd0, 32'h7F000000);
    exp_done.push_back({4'd0, 4'd2});
    run(4'd0);
    wait_done(20, n);

    // Write while busy is dropped and flagged; program still runs intact.
    load_prog3();
    instr_ready = 1'b0;
    push_prog3(4'd3);
    run(4'd0);
    wait_valid(10);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h03000000;
    tick();
    wr_en = 1'b0;
    check("busy_write_err", {28'd0, error_code}, 32'd3);
    instr_ready = 1'b1;
    wait_done(40, n);

    // Write and start together: FETCH sees the freshly written HALT.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h03000000;
    exp_done.push_back({4'd0, 4'd0});
    run(4'd0);
    wr_en = 1'b0;
    wait_done(20, n);

    // Reset while an instruction is offered, then rerun.
    load_prog3();
    instr_ready = 1'b0;
    exp_issue.push_back(32'h0100F000);
    run(4'd0);
    wait_valid(10);
    reset = 1'b0;
    tick();
    check("midrst_outputs", {instr_valid, busy, done, error_code, pc,
                             instr_op, instr_dev, instr_reg, instr_data}, 32'd0);
    void'(exp_issue.pop_front());
    reset = 1'b1;
    instr_ready = 1'b1;
    tick();
    push_prog3(4'd0);
    run(4'd0);
    wait_done(40, n);

    tick();
    check("queues_empty", exp_issue.size() + exp_done.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
